// File: rtl/pingpong_play_ctrl_pkg.sv
// rtl/pingpong_play_ctrl_pkg.sv - shared encodings and buffer constants for the ping-pong playback controller
package pingpong_play_ctrl_pkg;

    localparam int BUFFER_HALF_WORDS = 256;
    localparam int SAMPLE_BYTES      = 4;
    localparam int BUFFER_SIZE_BYTES = 2 * BUFFER_HALF_WORDS * SAMPLE_BYTES;
    localparam int BUFFER_ADDR_BITS  = $clog2(BUFFER_SIZE_BYTES);

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_PLAYING = 2'd3
    } buf_state_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LAST  = 3'd3,
        ST_STOP  = 3'd4
    } play_state_t;

endpackage

// File: rtl/pingpong_play_ctrl_sync_rise_detect.sv
// rtl/pingpong_play_ctrl_sync_rise_detect.sv - flop synchronizer plus registered rising-edge pulse for slow async flags
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Pulse lands SYNC_STAGES+1 cycles after the input is first sampled high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            last_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q     <= sync_q[SYNC_STAGES-1];
            rise_pulse <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/pingpong_play_ctrl.sv
// rtl/pingpong_play_ctrl.sv - two-half playback buffer sequencer for the I2S transmitter; PLAY_COUNTER_EN adds played_cnt_o
module pingpong_play_ctrl
    import pingpong_play_ctrl_pkg::*;
#(
    parameter int CNT_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic master_clock,
    input  logic reset,
    input  logic play_i,
    input  logic stop_i,
    output logic fill_req_o,
    output logic fill_sel_o,
    input  logic fill_done_i,
    input  logic fill_eof_i,
    input  logic i2s_empty_i,
    output logic i2s_filled_o,
    output logic i2s_run_o,
    output logic playing_o,
    output logic underrun_o,
    output logic done_o
`ifdef PLAY_COUNTER_EN
    ,
    output logic [CNT_BITS-1:0] played_cnt_o
`endif
);

    play_state_t state_q, state_d;
    buf_state_t  buf_q [2];
    buf_state_t  buf_d [2];
    logic        idx_q, idx_d;
    logic        req_q, req_d;
    logic        sel_q, sel_d;
    logic        underrun_q, underrun_d;
    logic        done_q, done_d;
    logic        rel, rel_play, done_ev;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_empty_sync (
        .clk        (master_clock),
        .reset      (reset),
        .async_in   (i2s_empty_i),
        .rise_pulse (rel)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        req_d      = req_q;
        sel_d      = sel_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        rel_play   = 1'b0;
        done_ev    = req_q & fill_done_i;
        case (state_q)
            ST_IDLE: begin
                if (play_i) begin
                    state_d    = ST_PRIME;
                    req_d      = 1'b1;
                    sel_d      = 1'b0;
                    buf_d[0]   = BUF_FILLING;
                    idx_d      = 1'b0;
                    underrun_d = 1'b0;
                end
            end
            ST_PRIME, ST_PLAY, ST_LAST: begin
                if (stop_i) begin
                    state_d = ST_STOP;
                    req_d   = req_q & ~fill_done_i;
                    buf_d   = '{BUF_EMPTY, BUF_EMPTY};
                    idx_d   = 1'b0;
                end else if (state_q == ST_PRIME) begin
                    if (done_ev) begin
                        req_d        = 1'b0;
                        buf_d[sel_q] = BUF_FULL;
                        if (fill_eof_i || sel_q) begin
                            buf_d[0] = BUF_PLAYING;
                            idx_d    = 1'b0;
                            state_d  = fill_eof_i ? ST_LAST : ST_PLAY;
                        end
                    end else if (!req_q && buf_q[1] == BUF_EMPTY) begin
                        req_d    = 1'b1;
                        sel_d    = 1'b1;
                        buf_d[1] = BUF_FILLING;
                    end
                end else begin
                    // Done is applied before rel so a half completed this cycle counts as FULL.
                    if (done_ev) begin
                        req_d        = 1'b0;
                        buf_d[sel_q] = (sel_q == idx_q) ? BUF_PLAYING : BUF_FULL;
                        if (fill_eof_i) state_d = ST_LAST;
                    end
                    if (rel) begin
                        rel_play      = 1'b1;
                        buf_d[idx_q]  = BUF_EMPTY;
                        idx_d         = ~idx_q;
                        if (buf_d[~idx_q] == BUF_FULL) begin
                            buf_d[~idx_q] = BUF_PLAYING;
                        end else if (state_d == ST_PLAY) begin
                            underrun_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                            buf_d   = '{BUF_EMPTY, BUF_EMPTY};
                            idx_d   = 1'b0;
                        end
                    end
                    if (state_d == ST_PLAY && !req_q) begin
                        if (buf_d[0] == BUF_EMPTY) begin
                            req_d    = 1'b1;
                            sel_d    = 1'b0;
                            buf_d[0] = BUF_FILLING;
                        end else if (buf_d[1] == BUF_EMPTY) begin
                            req_d    = 1'b1;
                            sel_d    = 1'b1;
                            buf_d[1] = BUF_FILLING;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (!req_q || fill_done_i) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            buf_q      <= '{BUF_EMPTY, BUF_EMPTY};
            idx_q      <= 1'b0;
            req_q      <= 1'b0;
            sel_q      <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

`ifdef PLAY_COUNTER_EN
    logic [CNT_BITS-1:0] cnt_q;

    always_ff @(posedge master_clock) begin
        if (reset || (state_q == ST_IDLE && play_i)) begin
            cnt_q <= '0;
        end else if (rel_play) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign played_cnt_o = cnt_q;
`else
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{CNT_BITS, rel_play};
`endif

    assign i2s_run_o    = (state_q == ST_PLAY) || (state_q == ST_LAST);
    assign playing_o    = i2s_run_o;
    assign i2s_filled_o = i2s_run_o && (buf_q[idx_q] == BUF_PLAYING);
    assign fill_req_o   = req_q;
    assign fill_sel_o   = sel_q;
    assign underrun_o   = underrun_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_pingpong_play_ctrl.sv
// tb/tb_pingpong_play_ctrl.sv - scoreboard bench for pingpong_play_ctrl
module tb_pingpong_play_ctrl;

    logic master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    logic reset = 1'b1, play_i = 1'b0, stop_i = 1'b0;
    logic fill_done_i = 1'b0, fill_eof_i = 1'b0, i2s_empty_i = 1'b0;
    logic fill_req_o, fill_sel_o, i2s_filled_o, i2s_run_o, playing_o, underrun_o, done_o;
`ifdef PLAY_COUNTER_EN
    logic [15:0] played_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    bit exp_sel_q[$];
    bit exp_done_q[$];
    logic req_prev = 1'b0;

    pingpong_play_ctrl #(.CNT_BITS(16), .SYNC_STAGES(2)) dut (
        .master_clock (master_clock),
        .reset        (reset),
        .play_i       (play_i),
        .stop_i       (stop_i),
        .fill_req_o   (fill_req_o),
        .fill_sel_o   (fill_sel_o),
        .fill_done_i  (fill_done_i),
        .fill_eof_i   (fill_eof_i),
        .i2s_empty_i  (i2s_empty_i),
        .i2s_filled_o (i2s_filled_o),
        .i2s_run_o    (i2s_run_o),
        .playing_o    (playing_o),
        .underrun_o   (underrun_o),
        .done_o       (done_o)
`ifdef PLAY_COUNTER_EN
        ,
        .played_cnt_o (played_cnt_o)
`endif
    );

    // Monitor: every new fill request and every done pulse is matched against the scoreboard.
    always @(negedge master_clock) begin
        if (fill_req_o === 1'b1 && req_prev !== 1'b1) begin
            checks++;
            if (exp_sel_q.size() == 0) begin
                errors++;
                $display("FAIL fill_req_unexpected: got request sel=%0d, required no request", fill_sel_o);
            end else begin
                automatic bit e = exp_sel_q.pop_front();
                if (fill_sel_o !== e) begin
                    errors++;
                    $display("FAIL fill_sel: got %0d required %0d", fill_sel_o, e);
                end
            end
        end
        if (done_o === 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done_o=1 required 0");
            end else begin
                void'(exp_done_q.pop_front());
            end
        end
        req_prev = fill_req_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_play();
        play_i = 1'b1;
        cyc(1);
        play_i = 1'b0;
    endtask

    task automatic serve(input int dly, input bit eof);
        int t = 0;
        while (fill_req_o !== 1'b1 && t < 200) begin
            cyc(1);
            t++;
        end
        chk("serve_req_seen", fill_req_o, 1);
        cyc(dly);
        fill_done_i = 1'b1;
        fill_eof_i  = eof;
        cyc(1);
        fill_done_i = 1'b0;
        fill_eof_i  = 1'b0;
    endtask

    task automatic rel_evt();
        i2s_empty_i = 1'b1;
        cyc(3);
        i2s_empty_i = 1'b0;
        cyc(3);
    endtask

    task automatic start_play();
        exp_sel_q.push_back(1'b0);
        exp_sel_q.push_back(1'b1);
        pulse_play();
        serve(10, 1'b0);
        serve(10, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_fill_req", fill_req_o, 0);
        chk("rst_fill_sel", fill_sel_o, 0);
        chk("rst_run", i2s_run_o, 0);
        chk("rst_filled", i2s_filled_o, 0);
        chk("rst_playing", playing_o, 0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_done", done_o, 0);

        // Normal start
        start_play();
        chk("start_run", i2s_run_o, 1);
        chk("start_filled", i2s_filled_o, 1);
        chk("start_playing", playing_o, 1);

        // Steady ping-pong
        for (int i = 0; i < 4; i++) begin
            exp_sel_q.push_back(1'(i % 2));
            rel_evt();
            serve(3, 1'b0);
        end
        chk("pp_underrun", underrun_o, 0);
        chk("pp_filled", i2s_filled_o, 1);
`ifdef PLAY_COUNTER_EN
        chk("pp_cnt", played_cnt_o, 4);
`endif

        // Underrun: hold back the half-0 fill across the next release
        exp_sel_q.push_back(1'b0);
        rel_evt();
        rel_evt();
        chk("ur_underrun", underrun_o, 1);
        chk("ur_filled", i2s_filled_o, 0);
        chk("ur_req", fill_req_o, 1);
        chk("ur_run", i2s_run_o, 1);
        exp_sel_q.push_back(1'b1);
        serve(0, 1'b0);
        chk("ur_filled_after_done", i2s_filled_o, 1);
        chk("ur_sticky", underrun_o, 1);
        serve(2, 1'b0);
`ifdef PLAY_COUNTER_EN
        chk("ur_cnt", played_cnt_o, 6);
`endif

        // End of stream on the 3rd done
        do_reset();
        start_play();
        exp_sel_q.push_back(1'b0);
        rel_evt();
        serve(3, 1'b1);
        chk("eos_playing", playing_o, 1);
        rel_evt();
        chk("eos_run_mid", i2s_run_o, 1);
        chk("eos_filled_mid", i2s_filled_o, 1);
        exp_done_q.push_back(1'b1);
        rel_evt();
        chk("eos_run", i2s_run_o, 0);
        chk("eos_playing_end", playing_o, 0);
        chk("eos_req", fill_req_o, 0);
        chk("eos_underrun", underrun_o, 0);
        cyc(10);
        chk("eos_done_seen", exp_done_q.size(), 0);

        // Stop with a fill outstanding, underrun already flagged
        do_reset();
        start_play();
        exp_sel_q.push_back(1'b0);
        rel_evt();
        rel_evt();
        chk("stop_pre_underrun", underrun_o, 1);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        chk("stop_run", i2s_run_o, 0);
        chk("stop_filled", i2s_filled_o, 0);
        chk("stop_playing", playing_o, 0);
        cyc(3);
        chk("stop_wait_req", fill_req_o, 1);
        fill_done_i = 1'b1;
        cyc(1);
        fill_done_i = 1'b0;
        chk("stop_req_cleared", fill_req_o, 0);
        exp_sel_q.push_back(1'b0);
        pulse_play();
        chk("restart_underrun", underrun_o, 0);
        chk("restart_sel", fill_sel_o, 0);
        chk("restart_req", fill_req_o, 1);
        exp_sel_q.push_back(1'b1);
        serve(2, 1'b0);
        serve(2, 1'b0);
        chk("restart_run", i2s_run_o, 1);

        // Coincident fill_done and rel
        do_reset();
        start_play();
        exp_sel_q.push_back(1'b0);
        rel_evt();
        exp_sel_q.push_back(1'b1);
        i2s_empty_i = 1'b1;
        cyc(3);
        fill_done_i = 1'b1;
        cyc(1);
        fill_done_i = 1'b0;
        chk("coin_underrun", underrun_o, 0);
        chk("coin_filled", i2s_filled_o, 1);
        i2s_empty_i = 1'b0;
        cyc(3);
        serve(2, 1'b0);

        // Reset mid-PLAY with a request pending
        exp_sel_q.push_back(1'b0);
        rel_evt();
        chk("prerst_req", fill_req_o, 1);
        reset = 1'b1;
        cyc(1);
        chk("midrst_req", fill_req_o, 0);
        chk("midrst_sel", fill_sel_o, 0);
        chk("midrst_run", i2s_run_o, 0);
        chk("midrst_filled", i2s_filled_o, 0);
        chk("midrst_playing", playing_o, 0);
        chk("midrst_underrun", underrun_o, 0);
        chk("midrst_done", done_o, 0);
`ifdef PLAY_COUNTER_EN
        chk("midrst_cnt", played_cnt_o, 0);
`endif
        reset = 1'b0;
        cyc(5);
        chk("sel_queue_drained", exp_sel_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_play_ctrl.md
Name: pingpong_play_ctrl

Overview:
- Sequences the two-half sample buffer shared by the upstream sample source (the buffer filler) and the I2S transmitter.
- Primes both halves, then hands each half to the transmitter with a filled flag.
- Refills whichever half the transmitter releases.
- Detects underrun, end-of-stream and stop, and holds the transmitter in reset whenever playback is not running.

Parameters:
- CNT_BITS, 16, width of the optional played-buffer counter.
- SYNC_STAGES, 2, synchronizer depth for the transmitter's empty flag (minimum 2).

Ports:
- master_clock  in  1  system clock, the same clock as the I2S divider source.
- reset  in  1  synchronous, active-high reset.
- play_i  in  1  one-cycle start pulse.
- stop_i  in  1  one-cycle stop pulse.
- fill_req_o  out  1  fill request to the source; level.
- fill_sel_o  out  1  buffer half to fill; stable while fill_req_o is high.
- fill_done_i  in  1  one-cycle pulse: the requested half has been written.
- fill_eof_i  in  1  qualifies fill_done_i: this fill is the last of the stream.
- i2s_empty_i  in  1  transmitter buffer-empty flag; arrives from the BCLK domain, treated as asynchronous.
- i2s_filled_o  out  1  to the transmitter's buffer-filled input.
- i2s_run_o  out  1  high = transmitter out of reset; drives the transmitter's active-low reset directly.
- playing_o  out  1  high in the PLAY and LAST states.
- underrun_o  out  1  sticky underrun flag.
- done_o  out  1  one-cycle pulse at natural end of stream.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, both buffer states EMPTY, play_idx = 0.
- Buffer state per half is one of: EMPTY, FILLING, FULL, PLAYING.
- i2s_empty_i passes through SYNC_STAGES flops and a rising-edge detector. This produces rel, a one-cycle pulse with latency of SYNC_STAGES+1 cycles.
- Fill handshake:
  - fill_req_o rises together with fill_sel_o, and that half goes to FILLING.
  - fill_req_o drops the cycle after fill_done_i, and that half goes to FULL.
  - fill_done_i is ignored while fill_req_o is low.
  - Only one fill is outstanding at a time.
  - A new request may be issued the cycle after done.
- IDLE:
  - play_i -> PRIME, and request a fill of half 0.
  - stop_i is ignored.
- PRIME:
  - After half 0 is done, request a fill of half 1.
  - When both halves are FULL -> PLAY: i2s_run_o=1, half 0 goes to PLAYING, play_idx=0.
  - fill_eof_i on the half 0 fill -> LAST immediately with only half 0 valid.
- PLAY:
  - i2s_filled_o = 1 iff half play_idx is PLAYING.
  - On rel: half play_idx goes to EMPTY, play_idx toggles (this tracks the transmitter's own select toggle), and a fill of the released half is requested.
  - If the new half is FULL it goes to PLAYING.
  - Otherwise underrun_o is set, i2s_filled_o is 0, and the half is promoted to PLAYING on its fill_done_i.
  - fill_done_i with fill_eof_i -> LAST; no further fills are issued.
- LAST:
  - The remaining FULL halves play out.
  - On rel with no FULL half remaining: done_o pulses, i2s_run_o=0, -> IDLE, buffers reset to EMPTY.
- stop_i in PRIME, PLAY or LAST -> STOP:
  - i2s_run_o=0 and i2s_filled_o=0 immediately.
  - Wait for the outstanding fill_done_i if fill_req_o is high, then -> IDLE with buffers EMPTY.
- Simultaneous events:
  - fill_done_i and rel in the same cycle: the done is applied first, so a half completed that cycle counts as FULL and no underrun is flagged.
  - stop_i has priority over play_i, rel and fill_done_i. A fill_done_i coinciding with stop_i still clears fill_req_o.
- underrun_o clears only on reset or on the next play_i.
- Reset mid-operation returns every output to its reset value in the cycle after reset is sampled. The transmitter is held in reset through i2s_run_o.

Optional Feature:
- Macro: PLAY_COUNTER_EN.
- Defined: adds output port played_cnt_o [CNT_BITS-1:0].
  - Increments on every rel in PLAY or LAST and wraps modulo 2^CNT_BITS.
  - Clears on play_i and on reset.
- Undefined: neither the port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - buffer-state encoding (EMPTY=0, FILLING=1, FULL=2, PLAYING=3);
  - FSM encoding (IDLE, PRIME, PLAY, LAST, STOP);
  - BUFFER_ADDR_BITS and BUFFER_SIZE_BYTES, alongside the existing buffer constants.
- One sub-module: sync_rise_detect (SYNC_STAGES flop synchronizer plus rising-edge pulse), reusable for other BCLK-to-master-clock flags.

Test Plan:
1. Normal start:
   - Stimulus: reset, then play_i; source answers each request with done 10 cycles later.
   - Response: fill_sel_o requests 0 then 1; i2s_run_o=1 and i2s_filled_o=1 after the second done; playing_o=1.
2. Steady ping-pong:
   - Stimulus: toggle i2s_empty_i 4 times.
   - Response: exactly 4 fill requests with fill_sel_o = 0,1,0,1; underrun_o stays 0; played_cnt_o=4 when PLAY_COUNTER_EN is defined.
3. Underrun:
   - Stimulus: delay fill_done_i until after the next rel.
   - Response: underrun_o=1 and i2s_filled_o=0 until the done; i2s_filled_o=1 the cycle after the done.
4. End of stream:
   - Stimulus: assert fill_eof_i on the 3rd done, then 2 further rel.
   - Response: no further fill requests; done_o pulses once; i2s_run_o=0; FSM returns to IDLE.
5. Stop with fill outstanding:
   - Stimulus: stop_i while fill_req_o=1.
   - Response: i2s_run_o=0 immediately; IDLE only after fill_done_i; a subsequent play_i clears underrun_o and restarts at half 0.
6. Coincident events and reset:
   - Stimulus: fill_done_i and rel in the same cycle; separately, reset asserted mid-PLAY.
   - Response: the coincident case flags no underrun; the reset case zeroes all outputs the next cycle.
